// File: rtl/data_cache_pkg.sv
// Shared types, widths and address field helpers for the data cache.
package data_cache_pkg;

  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 8;
  localparam int BLOCK_W    = 32;
  localparam int MEM_ADDR_W = 6;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    UPDATE    = 2'd3
  } state_e;

  // Block address: the byte address with the in-block offset removed.
  function automatic logic [MEM_ADDR_W-1:0] blk_of(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:ADDR_W-MEM_ADDR_W];
  endfunction

  function automatic logic [ADDR_W-MEM_ADDR_W-1:0] offset_of(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-MEM_ADDR_W-1:0];
  endfunction

  // Index and tag are returned at full block-address width; the caller
  // narrows them to its own INDEX_W / tag width.
  function automatic logic [MEM_ADDR_W-1:0] index_of(input logic [ADDR_W-1:0] a, input int iw);
    return blk_of(a) & ((MEM_ADDR_W'(1) << iw) - MEM_ADDR_W'(1));
  endfunction

  function automatic logic [MEM_ADDR_W-1:0] tag_of(input logic [ADDR_W-1:0] a, input int iw);
    return blk_of(a) >> iw;
  endfunction

endpackage

// File: rtl/data_cache_ctrl.sv
// Miss-handling FSM: state register, memory strobes and CPU stall.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   IDLE      | serving hits; a miss raises busywait and leaves
//   WRITEBACK | dirty victim block being written to memory
//   FETCH     | requested block being read from memory
//   UPDATE    | fetched block written into the line, then back to IDLE
module data_cache_ctrl
  import data_cache_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req,
  input  logic       hit,
  input  logic       victim_dirty,
  input  logic       mem_busywait,
  output logic [1:0] state,
  output logic       busywait,
  output logic       mem_read,
  output logic       mem_write,
  output logic       miss_start
);

  state_e state_r;
  state_e next_state;

  assign state = state_r;

  // State register with synchronous active-low reset; reset aborts any transfer.
  always_ff @(posedge clk) begin
    if (!reset_n) state_r <= IDLE;
    else          state_r <= next_state;
  end

  // Next-state and output decode; memory strobes depend on state only.
  always_comb begin
    next_state = state_r;
    busywait   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    miss_start = 1'b0;
    case (state_r)
      IDLE: begin
        // Gated with reset so a held request cannot stall the CPU during reset.
        if (req && !hit && reset_n) begin
          busywait   = 1'b1;
          miss_start = 1'b1;
          next_state = victim_dirty ? WRITEBACK : FETCH;
        end
      end
      WRITEBACK: begin
        busywait  = 1'b1;
        mem_write = 1'b1;
        if (!mem_busywait) next_state = FETCH;
      end
      FETCH: begin
        busywait = 1'b1;
        mem_read = 1'b1;
        if (!mem_busywait) next_state = UPDATE;
      end
      UPDATE: begin
        busywait   = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache.
// Optional hit/miss statistics ports are built when DATA_CACHE_STATS_EN is defined.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int INDEX_W  = 3,
  parameter int OFFSET_W = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [ADDR_W-1:0]     ADDRESS,
  input  logic [DATA_W-1:0]     WRITEDATA,
  output logic [DATA_W-1:0]     READDATA,
  output logic                  BUSYWAIT,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic [MEM_ADDR_W-1:0] MEM_ADDRESS,
  output logic [BLOCK_W-1:0]    MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0]    MEM_READDATA,
  input  logic                  MEM_BUSYWAIT
`ifdef DATA_CACHE_STATS_EN
  ,
  output logic [15:0]           HIT_COUNT,
  output logic [15:0]           MISS_COUNT
`endif
);

  localparam int TAG_W = MEM_ADDR_W - INDEX_W;
  localparam int LINES = 1 << INDEX_W;

  logic [BLOCK_W-1:0]    data_arr [LINES];
  logic [TAG_W-1:0]      tag_arr  [LINES];
  logic [LINES-1:0]      valid;
  logic [LINES-1:0]      dirty;

  logic [INDEX_W-1:0]    idx;
  logic [TAG_W-1:0]      tag;
  logic [OFFSET_W-1:0]   off;
  logic [MEM_ADDR_W-1:0] m_blk;
  logic [INDEX_W-1:0]    m_idx;
  logic [TAG_W-1:0]      m_tag;
  logic [BLOCK_W-1:0]    fetch_buf;
  logic [BLOCK_W-1:0]    cur_line;
  logic [1:0]            state;
  logic                  req, hit, in_idle, in_update, in_fetch, miss_start, wr_hit;

  assign idx = INDEX_W'(index_of(ADDRESS, INDEX_W));
  assign tag = TAG_W'(tag_of(ADDRESS, INDEX_W));
  assign off = OFFSET_W'(offset_of(ADDRESS));

  // The miss block address is captured when leaving IDLE so the refill
  // targets the right line even if the CPU misbehaves mid-miss.
  assign m_idx = m_blk[INDEX_W-1:0];
  assign m_tag = m_blk[MEM_ADDR_W-1:INDEX_W];

  assign req       = READ | WRITE;
  assign hit       = valid[idx] && (tag_arr[idx] == tag);
  assign in_idle   = (state_e'(state) == IDLE);
  assign in_fetch  = (state_e'(state) == FETCH);
  assign in_update = (state_e'(state) == UPDATE);
  assign wr_hit    = in_idle && WRITE && hit && RESET;
  assign cur_line  = data_arr[idx];

  data_cache_ctrl u_ctrl (
    .clk          (CLK),
    .reset_n      (RESET),
    .req          (req),
    .hit          (hit),
    .victim_dirty (valid[idx] & dirty[idx]),
    .mem_busywait (MEM_BUSYWAIT),
    .state        (state),
    .busywait     (BUSYWAIT),
    .mem_read     (MEM_READ),
    .mem_write    (MEM_WRITE),
    .miss_start   (miss_start)
  );

  // Load data only for a pure read that hits in IDLE; zero otherwise.
  assign READDATA = (in_idle && READ && !WRITE && hit) ? cur_line[{off, 3'b000} +: DATA_W] : '0;

  // Memory-side address/data follow the active strobe.
  always_comb begin
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;
    if (MEM_WRITE) begin
      MEM_ADDRESS   = {tag_arr[m_idx], m_idx};
      MEM_WRITEDATA = data_arr[m_idx];
    end else if (MEM_READ) begin
      MEM_ADDRESS   = m_blk;
    end
  end

  // Miss address capture and fetched-block holding register.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      m_blk     <= '0;
      fetch_buf <= '0;
    end else begin
      if (miss_start)                fetch_buf <= fetch_buf;
      if (miss_start)                m_blk     <= ADDRESS[ADDR_W-1:OFFSET_W];
      if (in_fetch && !MEM_BUSYWAIT) fetch_buf <= MEM_READDATA;
    end
  end

  // Valid/dirty bookkeeping: refill makes a line clean, a write hit dirties it.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      valid <= '0;
      dirty <= '0;
    end else if (in_update) begin
      valid[m_idx] <= 1'b1;
      dirty[m_idx] <= 1'b0;
    end else if (wr_hit) begin
      dirty[idx] <= 1'b1;
    end
  end

  // Data and tag storage; no reset needed since valid qualifies them.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      if (in_update) begin
        data_arr[m_idx] <= fetch_buf;
        tag_arr[m_idx]  <= m_tag;
      end else if (wr_hit) begin
        data_arr[idx][{off, 3'b000} +: DATA_W] <= WRITEDATA;
      end
    end
  end

`ifdef DATA_CACHE_STATS_EN
  logic after_refill;

  // Saturating counters; the hit that completes a refilled miss is not a hit.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      HIT_COUNT    <= '0;
      MISS_COUNT   <= '0;
      after_refill <= 1'b0;
    end else begin
      after_refill <= in_update;
      if (in_idle && req && hit && !after_refill && (HIT_COUNT != 16'hFFFF))
        HIT_COUNT <= HIT_COUNT + 16'd1;
      if (miss_start && (MISS_COUNT != 16'hFFFF))
        MISS_COUNT <= MISS_COUNT + 16'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_data_cache.sv
`timescale 1ns/1ps
module tb_data_cache;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        READ = 1'b0;
  logic        WRITE = 1'b0;
  logic [7:0]  ADDRESS = 8'h00;
  logic [7:0]  WRITEDATA = 8'h00;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA = 32'h0;
  logic        MEM_BUSYWAIT = 1'b0;
`ifdef DATA_CACHE_STATS_EN
  logic [15:0] HIT_COUNT;
  logic [15:0] MISS_COUNT;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  data_cache dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .READ          (READ),
    .WRITE         (WRITE),
    .ADDRESS       (ADDRESS),
    .WRITEDATA     (WRITEDATA),
    .READDATA      (READDATA),
    .BUSYWAIT      (BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
`ifdef DATA_CACHE_STATS_EN
    ,
    .HIT_COUNT     (HIT_COUNT),
    .MISS_COUNT    (MISS_COUNT)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Block memory with a per-transfer latency drawn from [lat_min, lat_max].
  logic [31:0] mem [64];
  int          lat_min = 0, lat_max = 0, cnt = 0, cur_lat = 0;
  int          wb_count = 0, rd_count = 0;
  logic [5:0]  last_wb_addr = 6'h0, last_rd_addr = 6'h0;
  logic [31:0] last_wb_data = 32'h0;

  initial forever begin
    @(posedge CLK); #2;
    if (MEM_READ || MEM_WRITE) begin
      if (cnt == 0) cur_lat = int'($urandom_range(lat_max, lat_min));
      if (cnt < cur_lat) begin
        MEM_BUSYWAIT = 1'b1;
        cnt++;
      end else begin
        MEM_BUSYWAIT = 1'b0;
        cnt = 0;
        if (MEM_WRITE) begin
          mem[MEM_ADDRESS] = MEM_WRITEDATA;
          wb_count++;
          last_wb_addr = MEM_ADDRESS;
          last_wb_data = MEM_WRITEDATA;
        end else begin
          MEM_READDATA = mem[MEM_ADDRESS];
          rd_count++;
          last_rd_addr = MEM_ADDRESS;
        end
      end
    end else begin
      MEM_BUSYWAIT = 1'b0;
      cnt = 0;
    end
  end

  initial forever begin
    @(negedge CLK);
    checks++;
    if (MEM_READ && MEM_WRITE) begin
      errors++;
      $display("FAIL strobe_exclusive actual=11 required=not both");
    end
  end

  // One CPU access, started at posedge+1; returns first-cycle stall,
  // number of stalled cycles and the data seen when BUSYWAIT is low.
  task automatic access(input logic wr, input logic rd, input logic [7:0] a, input logic [7:0] d,
                        output logic first_busy, output int stall, output logic [7:0] rdata);
    READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = d;
    stall = 0;
    @(negedge CLK);
    first_busy = BUSYWAIT;
    while (BUSYWAIT && stall < 64) begin
      stall++;
      @(negedge CLK);
    end
    check("access_timeout", {31'h0, BUSYWAIT}, 32'h0);
    rdata = READDATA;
    @(posedge CLK); #1;
    READ = 1'b0; WRITE = 1'b0;
  endtask

  // Architectural reference: a flat byte memory plus per-line tag state.
  logic [7:0] arch [256];
  logic       mvalid [8];
  logic       mdirty [8];
  int         mtag   [8];

  task automatic model_reset();
    logic [31:0] w;
    for (int a = 0; a < 256; a++) begin
      w = mem[a / 4];
      arch[a] = w[(a % 4) * 8 +: 8];
    end
    for (int i = 0; i < 8; i++) begin
      mvalid[i] = 1'b0; mdirty[i] = 1'b0; mtag[i] = 0;
    end
  endtask

  task automatic model_access(input logic wr, input logic rd, input logic [7:0] a, input logic [7:0] d);
    int         line, t, wb0, st;
    logic       exp_miss, exp_wb, fb;
    logic [7:0] rdata;
    line = (int'(a) / 4) % 8;
    t    = int'(a) / 32;
    exp_miss = !(mvalid[line] && mtag[line] == t);
    exp_wb   = exp_miss && mvalid[line] && mdirty[line];
    wb0 = wb_count;
    access(wr, rd, a, d, fb, st, rdata);
    check("rand_miss", {31'h0, fb}, {31'h0, exp_miss});
    check("rand_wb", wb_count - wb0, {31'h0, exp_wb});
    if (!wr) check("rand_rdata", {24'h0, rdata}, {24'h0, arch[a]});
    if (exp_miss) begin
      mvalid[line] = 1'b1; mtag[line] = t; mdirty[line] = 1'b0;
    end
    if (wr) begin
      arch[a] = d; mdirty[line] = 1'b1;
    end
  endtask

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         exp_stall;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic       fb;
    int         st, n;
    logic [7:0] rdata;
    logic       wr, rd;

    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[1] = 32'h44332211;
    mem[9] = 32'h88776655;

    vecs[0] = '{1'b0, 1'b1, 8'h05, 8'h00, 3, 8'h22};
    vecs[1] = '{1'b0, 1'b1, 8'h04, 8'h00, 0, 8'h11};
    vecs[2] = '{1'b1, 1'b0, 8'h06, 8'hAB, 0, 8'h00};
    vecs[3] = '{1'b0, 1'b1, 8'h06, 8'h00, 0, 8'hAB};
    vecs[4] = '{1'b0, 1'b1, 8'h25, 8'h00, 4, 8'h66};

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_busywait",  {31'h0, BUSYWAIT},  32'h0);
    check("rst_mem_read",  {31'h0, MEM_READ},  32'h0);
    check("rst_mem_write", {31'h0, MEM_WRITE}, 32'h0);
    check("rst_mem_addr",  {26'h0, MEM_ADDRESS}, 32'h0);
    check("rst_mem_wdata", MEM_WRITEDATA, 32'h0);
    check("rst_readdata",  {24'h0, READDATA}, 32'h0);
`ifdef DATA_CACHE_STATS_EN
    check("rst_hits",   {16'h0, HIT_COUNT},  32'h0);
    check("rst_misses", {16'h0, MISS_COUNT}, 32'h0);
`endif
    @(posedge CLK); #1;
    RESET = 1'b1;

    for (int i = 0; i < 5; i++) begin
      access(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, fb, st, rdata);
      check($sformatf("vec%0d_first_busy", i), {31'h0, fb}, {31'h0, vecs[i].exp_stall != 0});
      check($sformatf("vec%0d_stall", i), st, vecs[i].exp_stall);
      if (vecs[i].rd) check($sformatf("vec%0d_rdata", i), {24'h0, rdata}, {24'h0, vecs[i].exp_rdata});
      if (i == 0) check("fetch_addr_1", {26'h0, last_rd_addr}, 32'h01);
    end
    check("wb_count",  wb_count, 1);
    check("wb_addr",   {26'h0, last_wb_addr}, 32'h01);
    check("wb_data",   last_wb_data, 32'h44AB2211);
    check("fetch_addr_9", {26'h0, last_rd_addr}, 32'h09);
`ifdef DATA_CACHE_STATS_EN
    check("hit_count",  {16'h0, HIT_COUNT},  32'd3);
    check("miss_count", {16'h0, MISS_COUNT}, 32'd2);
`endif

    // READ and WRITE together act as a write.
    access(1'b1, 1'b1, 8'h24, 8'h5C, fb, st, rdata);
    check("both_stall", st, 0);
    access(1'b0, 1'b1, 8'h24, 8'h00, fb, st, rdata);
    check("both_readback", {24'h0, rdata}, 32'h5C);
    check("both_readback_stall", st, 0);

    // Reset during a long FETCH aborts it.
    lat_min = 10; lat_max = 10;
    READ = 1'b1; ADDRESS = 8'h05;
    n = 0;
    @(negedge CLK);
    while (!MEM_READ && n < 60) begin
      n++;
      @(negedge CLK);
    end
    check("reach_fetch", {31'h0, MEM_READ}, 32'h1);
    RESET = 1'b0;
    @(posedge CLK); #1;
    check("abort_mem_read", {31'h0, MEM_READ},  32'h0);
    check("abort_busywait", {31'h0, BUSYWAIT},  32'h0);
    check("abort_mem_addr", {26'h0, MEM_ADDRESS}, 32'h0);
    RESET = 1'b1; READ = 1'b0;
    lat_min = 0; lat_max = 2;
    model_reset();
    model_access(1'b0, 1'b1, 8'h05, 8'h00);

    for (int i = 0; i < 400; i++) begin
      wr = ($urandom_range(2, 0) == 0);
      rd = wr ? ($urandom_range(3, 0) == 0) : 1'b1;
      model_access(wr, rd, 8'($urandom_range(255, 0)), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
